// File: rtl/inst_encoder.sv
// inst_encoder: streaming RV32I encoder packing fields and immediates into instruction words with IMEM addresses
// INST_ENC_RANGE_CHECK_EN enables misaligned, range and U-low-bit checks; without it only bad formats are flagged
module inst_encoder #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int CNT_W = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   output logic in_ready,
   input  logic [5:0] in_fmt,
   input  logic [6:0] in_opcode,
   input  logic [4:0] in_rd,
   input  logic [4:0] in_rs1,
   input  logic [4:0] in_rs2,
   input  logic [2:0] in_funct3,
   input  logic [6:0] in_funct7,
   input  logic [31:0] in_imm,
   output logic out_valid,
   input  logic out_ready,
   output logic [31:0] out_inst,
   output logic [31:0] out_addr,
   output logic out_err,
   output logic [2:0] out_err_code,
   output logic err_sticky,
   input  logic clr,
   output logic [CNT_W-1:0] inst_count,
   output logic [CNT_W-1:0] err_count
);
   localparam logic [31:0] NOP = 32'h0000_0013;
   logic f_sh, f_i, f_s, f_b, f_u, f_j;
   logic onehot;
   logic [31:0] r;
   logic [31:0] enc_inst;
   logic [2:0] enc_code;
   logic [31:0] new_inst;
   assign {f_sh, f_i, f_s, f_b, f_u, f_j} = in_fmt;
   assign r = in_imm;
   assign onehot = (in_fmt != '0) && ((in_fmt & (in_fmt - 6'd1)) == '0);
   always_comb
      enc_inst = f_sh ? {in_funct7, r[4:0], in_rs1, in_funct3, in_rd, in_opcode}
               : f_s  ? {r[11:5], in_rs2, in_rs1, in_funct3, r[4:0], in_opcode}
               : f_b  ? {r[12], r[10:5], in_rs2, in_rs1, in_funct3, r[4:1], r[11], in_opcode}
               : f_u  ? {r[31:12], in_rd, in_opcode}
               : f_j  ? {r[20], r[10:1], r[11], r[19:12], in_rd, in_opcode}
               : {r[11:0], in_rs1, in_funct3, in_rd, in_opcode};
`ifdef INST_ENC_RANGE_CHECK_EN
   logic misaligned, out_of_range, u_low;
   // an immediate fits its field when every bit above the field's sign bit repeats it
   assign misaligned = (f_b | f_j) & r[0];
   assign out_of_range = ((f_i | f_s) & (r[31:11] != {21{r[11]}}))
                       | (f_sh & (r[31:5] != '0))
                       | (f_b & (r[31:12] != {20{r[12]}}))
                       | (f_j & (r[31:20] != {12{r[20]}}));
   assign u_low = f_u & (r[11:0] != '0);
   assign enc_code = !onehot ? 3'd1 : misaligned ? 3'd2 : out_of_range ? 3'd3 : u_low ? 3'd4 : 3'd0;
`else
   assign enc_code = onehot ? 3'd0 : 3'd1;
`endif
   assign new_inst = (enc_code != 3'd0) ? NOP : enc_inst;
   logic [31:0] skid_inst;
   logic skid_err;
   logic [2:0] skid_code;
   logic skid_valid;
   logic accept, fire, load;
   assign accept = in_valid & in_ready;
   assign fire = out_valid & out_ready;
   assign load = ~out_valid | out_ready;
   // skid only fills while the main register is stalled, so in_ready mirrors its emptiness
   always_ff @(posedge clk)
      if (rst) begin
         out_valid <= 1'b0;
         out_inst <= '0;
         out_err <= 1'b0;
         out_err_code <= '0;
         skid_valid <= 1'b0;
         skid_inst <= '0;
         skid_err <= 1'b0;
         skid_code <= '0;
         in_ready <= 1'b1;
      end else begin
         if (load) begin
            out_valid <= skid_valid | accept;
            if (skid_valid) begin
               out_inst <= skid_inst;
               out_err <= skid_err;
               out_err_code <= skid_code;
            end else if (accept) begin
               out_inst <= new_inst;
               out_err <= enc_code != 3'd0;
               out_err_code <= enc_code;
            end
         end else if (accept) begin
            skid_inst <= new_inst;
            skid_err <= enc_code != 3'd0;
            skid_code <= enc_code;
         end
         skid_valid <= load ? 1'b0 : (skid_valid | accept);
         in_ready <= load | ~(skid_valid | accept);
      end
   always_ff @(posedge clk)
      if (rst) begin
         out_addr <= BASE_ADDR;
         inst_count <= '0;
         err_count <= '0;
         err_sticky <= 1'b0;
      end else begin
         if (fire) out_addr <= out_addr + 32'd4;
         if (clr) begin
            inst_count <= '0;
            err_count <= '0;
            err_sticky <= 1'b0;
         end else if (fire) begin
            if (inst_count != '1) inst_count <= inst_count + CNT_W'(1);
            if (out_err && err_count != '1) err_count <= err_count + CNT_W'(1);
            if (out_err) err_sticky <= 1'b1;
         end
      end
endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: vector table, hand-written handshake corners and randomized traffic against a field-level model
`timescale 1ns/1ps
module tb_inst_encoder;
   localparam logic [31:0] BASE = 32'h0000_1000;
   localparam int CW = 4;
   localparam int SAT = (1 << CW) - 1;
`ifdef INST_ENC_RANGE_CHECK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif
   localparam logic [5:0] F_SH = 6'b100000, F_I = 6'b010000, F_S = 6'b001000,
                          F_B = 6'b000100, F_U = 6'b000010, F_J = 6'b000001;
   typedef struct packed {
      logic [5:0] fmt; logic [6:0] op; logic [4:0] rd; logic [4:0] rs1; logic [4:0] rs2;
      logic [2:0] f3; logic [6:0] f7; logic [31:0] imm;
   } beat_t;
   typedef struct packed { logic [31:0] inst; logic [2:0] code; } exp_t;
   typedef struct packed {
      beat_t b; logic [31:0] inst_rc; logic [2:0] code_rc; logic [31:0] inst_nr; logic [2:0] code_nr;
   } vec_t;
   logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0, clr = 1'b0;
   logic in_ready, out_valid, out_err, err_sticky;
   logic [31:0] out_inst, out_addr;
   logic [2:0] out_err_code;
   logic [CW-1:0] inst_count, err_count;
   beat_t cb = '0;
   inst_encoder #(.BASE_ADDR(BASE), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_fmt(cb.fmt), .in_opcode(cb.op), .in_rd(cb.rd), .in_rs1(cb.rs1), .in_rs2(cb.rs2),
      .in_funct3(cb.f3), .in_funct7(cb.f7), .in_imm(cb.imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_addr(out_addr),
      .out_err(out_err), .out_err_code(out_err_code), .err_sticky(err_sticky), .clr(clr),
      .inst_count(inst_count), .err_count(err_count));
   always #5 clk = ~clk;
   int total = 0, bad = 0;
   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endfunction
   // reference: field extraction by shift/mask, legality by signed value comparison
   function automatic exp_t ref_enc(beat_t b);
      exp_t e;
      int v;
      logic [31:0] r, p, lo;
      r = b.imm;
      v = $signed(b.imm);
      lo = (32'(b.rd) << 7) | 32'(b.op);
      e.code = 3'd0;
      if ($countones(b.fmt) != 1) e.code = 3'd1;
      else if (RC) begin
         if ((b.fmt == F_B || b.fmt == F_J) && (r % 2 == 1)) e.code = 3'd2;
         else if (((b.fmt == F_I || b.fmt == F_S) && (v < -2048 || v > 2047)) ||
                  (b.fmt == F_SH && r > 31) ||
                  (b.fmt == F_B && (v < -4096 || v > 4094)) ||
                  (b.fmt == F_J && (v < -1048576 || v > 1048574))) e.code = 3'd3;
         else if (b.fmt == F_U && (r % 4096 != 0)) e.code = 3'd4;
      end
      if (b.fmt == F_SH)
         p = (32'(b.f7) << 25) | ((r & 31) << 20) | (32'(b.rs1) << 15) | (32'(b.f3) << 12) | lo;
      else if (b.fmt == F_S)
         p = (((r >> 5) & 127) << 25) | (32'(b.rs2) << 20) | (32'(b.rs1) << 15) | (32'(b.f3) << 12) | ((r & 31) << 7) | 32'(b.op);
      else if (b.fmt == F_B)
         p = (((r >> 12) & 1) << 31) | (((r >> 5) & 63) << 25) | (32'(b.rs2) << 20) | (32'(b.rs1) << 15)
           | (32'(b.f3) << 12) | (((r >> 1) & 15) << 8) | (((r >> 11) & 1) << 7) | 32'(b.op);
      else if (b.fmt == F_U)
         p = (r & 32'hFFFF_F000) | lo;
      else if (b.fmt == F_J)
         p = (((r >> 20) & 1) << 31) | (((r >> 1) & 1023) << 21) | (((r >> 11) & 1) << 20) | (((r >> 12) & 255) << 12) | lo;
      else
         p = ((r & 4095) << 20) | (32'(b.rs1) << 15) | (32'(b.f3) << 12) | lo;
      e.inst = (e.code != 0) ? 32'h13 : p;
      return e;
   endfunction
   exp_t q[$];
   logic [31:0] m_addr = BASE;
   int m_ic = 0, m_ec = 0;
   logic m_st = 1'b0;
   bit mon_en = 1'b0;
   always @(negedge clk) if (mon_en) begin
      int occ;
      exp_t e;
      occ = q.size();
      chk("out_valid", 32'(out_valid), 32'(occ > 0));
      chk("in_ready", 32'(in_ready), 32'(occ < 2));
      chk("out_addr", out_addr, m_addr);
      chk("inst_count", 32'(inst_count), 32'(m_ic));
      chk("err_count", 32'(err_count), 32'(m_ec));
      chk("err_sticky", 32'(err_sticky), 32'(m_st));
      if (occ > 0) begin
         chk("sb inst", out_inst, q[0].inst);
         chk("sb code", 32'(out_err_code), 32'(q[0].code));
         chk("sb err", 32'(out_err), 32'(q[0].code != 0));
      end
      if (rst) begin
         q.delete();
         m_addr = BASE; m_ic = 0; m_ec = 0; m_st = 1'b0;
      end else begin
         if (occ > 0 && out_ready) begin
            e = q.pop_front();
            m_addr += 32'd4;
            m_ic = (m_ic < SAT) ? m_ic + 1 : m_ic;
            if (e.code != 0) begin
               m_ec = (m_ec < SAT) ? m_ec + 1 : m_ec;
               m_st = 1'b1;
            end
         end
         if (clr) begin m_ic = 0; m_ec = 0; m_st = 1'b0; end
         if (in_valid && occ < 2) q.push_back(ref_enc(cb));
      end
   end
   function automatic beat_t mkb(logic [5:0] f, logic [6:0] op, logic [4:0] rd, logic [4:0] rs1,
                                 logic [4:0] rs2, logic [2:0] f3, logic [6:0] f7, logic [31:0] imm);
      beat_t b;
      b.fmt = f; b.op = op; b.rd = rd; b.rs1 = rs1; b.rs2 = rs2; b.f3 = f3; b.f7 = f7; b.imm = imm;
      return b;
   endfunction
   function automatic vec_t mkv(beat_t b, logic [31:0] irc, logic [2:0] crc, logic [31:0] inr, logic [2:0] cnr);
      vec_t v;
      v.b = b; v.inst_rc = irc; v.code_rc = crc; v.inst_nr = inr; v.code_nr = cnr;
      return v;
   endfunction
   task automatic send(input beat_t b);
      bit ok;
      int n;
      n = 0;
      cb = b;
      in_valid = 1'b1;
      do begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk); #1;
         n++;
      end while (!ok && n < 50);
      chk("send accepted", 32'(ok), 32'd1);
      in_valid = 1'b0;
   endtask
   function automatic logic [31:0] rnd_imm();
      int bl[17] = '{-2049, -2048, 2047, 2048, 31, 32, -4096, -4098, 4094, 4096,
                     -1048576, -1048578, 1048574, 1048576, 0, 1, -1};
      case ($urandom_range(0, 3))
         0: return $urandom;
         1: return $urandom & 32'hFFFF_F000;
         2: return 32'($urandom_range(0, 80)) - 32'd40;
         default: return 32'(bl[$urandom_range(0, 16)] + $urandom_range(0, 2) - 1);
      endcase
   endfunction
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      vec_t vt[$];
      beat_t a;
      vt.push_back(mkv(mkb(F_I, 7'h13, 1, 0, 0, 0, 0, 32'hFFFF_FFFF), 32'hFFF00093, 0, 32'hFFF00093, 0));
      vt.push_back(mkv(mkb(F_B, 7'h63, 0, 0, 0, 0, 0, 32'hFFFF_FFFC), 32'hFE000EE3, 0, 32'hFE000EE3, 0));
      vt.push_back(mkv(mkb(F_U, 7'h37, 5, 0, 0, 0, 0, 32'h1234_5000), 32'h123452B7, 0, 32'h123452B7, 0));
      vt.push_back(mkv(mkb(F_J, 7'h6F, 0, 0, 0, 0, 0, 32'd3), 32'h13, 2, 32'h0020006F, 0));
      vt.push_back(mkv(mkb(F_I, 7'h13, 1, 0, 0, 0, 0, 32'd2048), 32'h13, 3, 32'h80000093, 0));
      vt.push_back(mkv(mkb(6'b000011, 7'h13, 1, 0, 0, 0, 0, 32'd0), 32'h13, 1, 32'h13, 1));
      vt.push_back(mkv(mkb(F_SH, 7'h13, 3, 2, 0, 5, 7'h20, 32'd5), 32'h40515193, 0, 32'h40515193, 0));
      vt.push_back(mkv(mkb(F_SH, 7'h13, 3, 2, 0, 5, 7'h20, 32'd32), 32'h13, 3, 32'h40015193, 0));
      vt.push_back(mkv(mkb(F_S, 7'h23, 0, 2, 3, 2, 0, 32'hFFFF_FFFF), 32'hFE312FA3, 0, 32'hFE312FA3, 0));
      vt.push_back(mkv(mkb(F_U, 7'h37, 5, 0, 0, 0, 0, 32'h1234_5001), 32'h13, 4, 32'h123452B7, 0));
      vt.push_back(mkv(mkb(F_B, 7'h63, 0, 0, 0, 0, 0, 32'd4094), 32'h7E000FE3, 0, 32'h7E000FE3, 0));
      vt.push_back(mkv(mkb(F_B, 7'h63, 0, 0, 0, 0, 0, 32'd4096), 32'h13, 3, 32'h80000063, 0));
      vt.push_back(mkv(mkb(F_J, 7'h6F, 1, 0, 0, 0, 0, 32'hFFF0_0000), 32'h800000EF, 0, 32'h800000EF, 0));
      vt.push_back(mkv(mkb(6'b000000, 7'h13, 1, 0, 0, 0, 0, 32'd0), 32'h13, 1, 32'h13, 1));
      vt.push_back(mkv(mkb(F_I, 7'h13, 1, 0, 0, 0, 0, 32'hFFFF_F800), 32'h80000093, 0, 32'h80000093, 0));
      vt.push_back(mkv(mkb(F_I, 7'h13, 1, 0, 0, 0, 0, 32'hFFFF_F7FF), 32'h13, 3, 32'h7FF00093, 0));
      vt.push_back(mkv(mkb(F_J, 7'h6F, 1, 0, 0, 0, 0, 32'd1048574), 32'h7FFFF0EF, 0, 32'h7FFFF0EF, 0));
      vt.push_back(mkv(mkb(F_J, 7'h6F, 1, 0, 0, 0, 0, 32'd1048576), 32'h13, 3, 32'h800000EF, 0));
      repeat (2) @(posedge clk);
      #1;
      mon_en = 1'b1;
      rst = 1'b0;
      @(negedge clk);
      chk("reset out_inst", out_inst, 32'h0);
      chk("reset out_err_code", 32'(out_err_code), 32'h0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      foreach (vt[i]) begin
         send(vt[i].b);
         @(negedge clk);
         chk($sformatf("vec%0d inst", i), out_inst, RC ? vt[i].inst_rc : vt[i].inst_nr);
         chk($sformatf("vec%0d code", i), 32'(out_err_code), 32'(RC ? vt[i].code_rc : vt[i].code_nr));
         chk($sformatf("vec%0d err", i), 32'(out_err), 32'((RC ? vt[i].code_rc : vt[i].code_nr) != 0));
         chk($sformatf("vec%0d addr", i), out_addr, BASE + 32'(4 * i));
         @(posedge clk); #1;
      end
      // backpressure: main + skid fill, third beat must wait
      a = mkb(F_I, 7'h13, 7, 1, 0, 0, 0, 32'd100);
      out_ready = 1'b0;
      cb = a; in_valid = 1'b1;
      @(posedge clk); #1;
      cb = mkb(F_I, 7'h13, 8, 1, 0, 0, 0, 32'd200);
      @(posedge clk); #1;
      cb = mkb(F_I, 7'h13, 9, 1, 0, 0, 0, 32'd300);
      @(negedge clk);
      chk("bp in_ready low", 32'(in_ready), 32'd0);
      chk("bp head inst", out_inst, 32'h06408393);
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp still stalled", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(mkb(F_I, 7'h13, 9, 1, 0, 0, 0, 32'd300));
      repeat (4) @(posedge clk);
      #1;
      @(negedge clk);
      chk("bp drained", 32'(out_valid), 32'd0);
      // reset with main and skid both full
      @(posedge clk); #1;
      out_ready = 1'b0;
      cb = mkb(F_U, 7'h37, 2, 0, 0, 0, 0, 32'h0000_1000); in_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("pre-rst skid full", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst in_ready", 32'(in_ready), 32'd1);
      chk("rst out_addr", out_addr, BASE);
      chk("rst inst_count", 32'(inst_count), 32'd0);
      chk("rst out_inst", out_inst, 32'd0);
      // error beat, then clr coinciding with a second error transfer
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(mkb(6'b000011, 7'h13, 1, 0, 0, 0, 0, 32'd0));
      @(posedge clk); #1;
      @(negedge clk);
      chk("err_count one", 32'(err_count), 32'd1);
      chk("sticky set", 32'(err_sticky), 32'd1);
      out_ready = 1'b0;
      @(posedge clk); #1;
      send(mkb(6'b110000, 7'h13, 1, 0, 0, 0, 0, 32'd0));
      out_ready = 1'b1; clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      @(negedge clk);
      chk("clr err_count", 32'(err_count), 32'd0);
      chk("clr sticky", 32'(err_sticky), 32'd0);
      chk("clr inst_count", 32'(inst_count), 32'd0);
      chk("clr keeps addr", out_addr, BASE + 32'd8);
      // counter saturation
      @(posedge clk); #1;
      for (int i = 0; i < 20; i++) send(mkb(F_I, 7'h13, 5'(i), 0, 0, 0, 0, 32'(i)));
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("inst_count saturated", 32'(inst_count), 32'(SAT));
      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         cb.fmt = ($urandom_range(0, 99) < 85) ? 6'(1 << $urandom_range(0, 5)) : 6'($urandom);
         cb.op = 7'($urandom); cb.rd = 5'($urandom); cb.rs1 = 5'($urandom); cb.rs2 = 5'($urandom);
         cb.f3 = 3'($urandom); cb.f7 = 7'($urandom); cb.imm = rnd_imm();
         in_valid = $urandom_range(0, 9) < 7;
         out_ready = $urandom_range(0, 9) < 7;
         clr = $urandom_range(0, 39) == 0;
         rst = $urandom_range(0, 499) == 0;
      end
      @(posedge clk); #1;
      in_valid = 1'b0; clr = 1'b0; rst = 1'b0; out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      @(negedge clk);
      chk("final drained", 32'(out_valid), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Streaming RISC-V RV32I instruction encoder: packs opcode, register fields and a 32-bit immediate into a 32-bit instruction word.
- It is the inverse of the immediate-generation path. The format select uses the same one-hot EXTOp encoding from ctrl_encode_def.v.
- It sits between the test/boot sequencer and the instruction-memory write port, and emits each word with its IMEM byte address.
- It checks that each immediate is representable in its format and flags any that is not.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first emitted word.
- CNT_W, 16, width of the instruction and error counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  encoder can accept a beat.
- in_fmt  in  6  one-hot format: 100000 SHAMT, 010000 I, 001000 S, 000100 B, 000010 U, 000001 J.
- in_opcode  in  7  inst[6:0].
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_funct3  in  3  funct3 field.
- in_funct7  in  7  funct7 field (SHAMT format only).
- in_imm  in  32  immediate as a signed byte offset/value (U: full value, low 12 bits expected zero).
- out_valid  out  1  output beat valid.
- out_ready  in  1  sink accepts the beat.
- out_inst  out  32  encoded instruction; 32'h0000_0013 (NOP) on error.
- out_addr  out  32  IMEM byte address of this beat.
- out_err  out  1  this beat is an encode error.
- out_err_code  out  3  0 none, 1 bad fmt, 2 misaligned, 3 out of range, 4 U low bits nonzero.
- err_sticky  out  1  set by any error beat; cleared only by rst or clr.
- clr  in  1  synchronous clear of err_sticky and both counters (address counter untouched).
- inst_count  out  CNT_W  count of output beats transferred.
- err_count  out  CNT_W  count of error beats transferred.

Behaviour:
- Clock/reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: out_valid=0, in_ready=1, out_inst=0, out_addr=BASE_ADDR, out_err=0, out_err_code=0, err_sticky=0, both counters 0, skid buffer empty.
- Handshake: transfer happens when valid and ready are both high. Payload and valid are held stable while out_valid && !out_ready.
- Latency: 1 cycle from input transfer to out_valid.
- Buffering: main output register plus one skid register. in_ready is registered and equals "skid empty". With no backpressure, throughput is 1 beat/cycle.
- On stall, the next accepted beat goes to the skid register and in_ready drops the following cycle. When the main register drains, the skid contents move to the main register and in_ready returns high.
- Ordering: beats always leave in acceptance order.
- Packing (r = in_imm):
  - I: {r[11:0], rs1, f3, rd, op}.
  - SHAMT: {funct7, r[4:0], rs1, f3, rd, op}.
  - S: {r[11:5], rs2, rs1, f3, r[4:0], op}.
  - B: {r[12], r[10:5], rs2, rs1, f3, r[4:1], r[11], op}.
  - U: {r[31:12], rd, op}.
  - J: {r[20], r[10:1], r[11], r[19:12], rd, op}.
- Check priority (first failing check wins):
  1. in_fmt not exactly one-hot: code 1.
  2. B or J with r[0]=1: code 2.
  3. Range violation: code 3. Allowed ranges are I/S in [-2048, 2047]; SHAMT in [0, 31] unsigned; B in [-4096, 4094]; J in [-1048576, 1048574].
  4. U with r[11:0] != 0: code 4.
- Error beats: out_inst=NOP, out_err=1; they still consume an address.
- Counters and address: on each output transfer, out_addr advances by 4 for the next beat and inst_count increments. If out_err, err_count increments and err_sticky is set.
  - Counters saturate at all-ones.
  - out_addr wraps modulo 2^32.
- clr during an error transfer: clr wins. Counters go to 0 and err_sticky to 0 in that cycle.
- rst mid-stream: all in-flight beats are discarded and the next cycle shows reset values.

Optional Feature:
- Macro INST_ENC_RANGE_CHECK_EN.
- Defined: checks 2, 3 and 4 above are active.
- Undefined: only check 1 (bad fmt) is active. Out-of-range and misaligned immediates are silently truncated by the packing rules; codes 2, 3 and 4 never occur.

Test Plan:
1. I fmt, op=0010011, rd=1, rs1=0, f3=0, imm=32'hFFFF_FFFF -> out_inst=32'hFFF00093, err=0, out_addr=BASE_ADDR, 1 cycle later.
2. B fmt, op=1100011, rs1=rs2=0, f3=0, imm=-4 -> 32'hFE000EE3, err=0. Then U fmt, op=0110111, rd=5, imm=32'h12345000 -> 32'h123452B7 at BASE_ADDR+4.
3. J fmt, imm=3 -> out_inst=32'h00000013, err=1, code=2, err_sticky=1, err_count=1. I fmt, imm=2048 -> code 3. in_fmt=6'b000011 -> code 1.
4. Backpressure: out_ready=0 for 3 cycles while 3 valid beats are offered -> 2 beats accepted and in_ready=0 after the skid fills. After release, beats emerge in order with consecutive addresses and none are lost.
5. rst asserted while out_valid=1 and skid full -> next cycle out_valid=0, in_ready=1, out_addr=BASE_ADDR, counters 0. clr coincident with an error transfer -> err_count=0, err_sticky=0.
6. Build without INST_ENC_RANGE_CHECK_EN: J imm=3 -> err=0, inst packed with r[0] dropped. Bad fmt -> code 1 still reported.
